// File: rtl/shift_extend_pkg.sv
// rtl/shift_extend_pkg.sv - shared encodings and state type for the shift/extend unit
package shift_extend_pkg;

    localparam logic [1:0] MODE_LOGICAL  = 2'b00;
    localparam logic [1:0] MODE_ARITH    = 2'b01;
    localparam logic [1:0] MODE_ROTATE   = 2'b10;
    localparam logic [1:0] MODE_RESERVED = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    // The reserved encoding behaves exactly like a logical shift.
    function automatic logic [1:0] normMode(input logic [1:0] m);
        return (m == MODE_RESERVED) ? MODE_LOGICAL : m;
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one combinational shift/rotate step of k bits
module shift_step
    import shift_extend_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int KW    = 5
) (
    input  logic [WIDTH-1:0] dataIn,
    input  logic [KW-1:0]    k,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             fillBit,
    output logic [WIDTH-1:0] dataOut
);

    logic [2*WIDTH-1:0] wideIn;
    logic [2*WIDTH-1:0] wideOut;

    // The upper half carries the bits that shift in: a copy of the operand
    // for rotate, the sign for arithmetic right, zeros otherwise.
    always_comb begin
        wideIn  = {{WIDTH{1'b0}}, dataIn};
        wideOut = '0;
        dataOut = '0;
        if (mode == MODE_ROTATE) begin
            wideIn = {dataIn, dataIn};
        end else if (dir == DIR_RIGHT && mode == MODE_ARITH) begin
            wideIn = {{WIDTH{fillBit}}, dataIn};
        end
        if (dir == DIR_RIGHT) begin
            wideOut = wideIn >> k;
            dataOut = wideOut[WIDTH-1:0];
        end else begin
            wideOut = wideIn << k;
            dataOut = (mode == MODE_ROTATE) ? wideOut[2*WIDTH-1:WIDTH] : wideOut[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/shift_extend_unit.sv
// rtl/shift_extend_unit.sv - iterative shifter with registered immediate zero/sign extension
module shift_extend_unit
    import shift_extend_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int IMM_WIDTH = 12,
    parameter int AMT_WIDTH = 5,
    parameter int STEP      = 1
) (
    input  logic                 CLK,
    input  logic                 Rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     ShifterIn,
    input  logic [AMT_WIDTH-1:0] amt,
    input  logic                 dir,
    input  logic [1:0]           mode,
    input  logic [IMM_WIDTH-1:0] imm,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     ShifterOut,
    output logic [WIDTH-1:0]     ZeroExtOut,
    output logic [WIDTH-1:0]     SignExtOut
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int EXT_W = ((AMT_WIDTH > CNT_W) ? AMT_WIDTH : CNT_W) + 1;
    localparam logic [CNT_W-1:0] STEP_CNT = CNT_W'(STEP);

    state_t state;
    state_t nextState;

    logic [WIDTH-1:0] workReg;
    logic [CNT_W-1:0] remaining;
    logic             opDir;
    logic [1:0]       opMode;
    logic             opMsb;

    logic             accept;
    logic [1:0]       inMode;
    logic [EXT_W-1:0] amtExt;
    logic [CNT_W-1:0] effAmt;
    logic [CNT_W-1:0] stepAmt;
    logic             lastStep;
    logic [WIDTH-1:0] stepOut;

    // Saturating at WIDTH makes over-long logical/arithmetic shifts land on
    // all-zero or all-sign without needing a separate saturation path.
    always_comb begin
        inMode = normMode(mode);
        amtExt = EXT_W'(amt);
        effAmt = '0;
        if (inMode == MODE_ROTATE) begin
            effAmt = CNT_W'(amtExt & EXT_W'(WIDTH - 1));
        end else if (amtExt >= EXT_W'(WIDTH)) begin
            effAmt = CNT_W'(WIDTH);
        end else begin
            effAmt = CNT_W'(amtExt);
        end
    end

    assign accept   = start && (state == S_IDLE || state == S_DONE);
    assign stepAmt  = (remaining < STEP_CNT) ? remaining : STEP_CNT;
    assign lastStep = (remaining == stepAmt);
    assign busy     = (state == S_SHIFT);
    assign done     = (state == S_DONE);

    shift_step #(
        .WIDTH (WIDTH),
        .KW    (CNT_W)
    ) u_step (
        .dataIn  (workReg),
        .k       (stepAmt),
        .dir     (opDir),
        .mode    (opMode),
        .fillBit (opMsb),
        .dataOut (stepOut)
    );

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    nextState = (effAmt == '0) ? S_DONE : S_SHIFT;
                end else begin
                    nextState = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (lastStep) begin
                    nextState = S_DONE;
                end
            end
            default: nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            workReg    <= '0;
            remaining  <= '0;
            opDir      <= DIR_LEFT;
            opMode     <= MODE_LOGICAL;
            opMsb      <= 1'b0;
            ShifterOut <= '0;
            ZeroExtOut <= '0;
            SignExtOut <= '0;
        end else if (accept) begin
            workReg    <= ShifterIn;
            remaining  <= effAmt;
            opDir      <= dir;
            opMode     <= inMode;
            opMsb      <= ShifterIn[WIDTH-1];
            ZeroExtOut <= {{(WIDTH - IMM_WIDTH){1'b0}}, imm};
            SignExtOut <= {{(WIDTH - IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
            if (effAmt == '0) begin
                ShifterOut <= ShifterIn;
            end
        end else if (state == S_SHIFT) begin
            workReg   <= stepOut;
            remaining <= remaining - stepAmt;
            if (lastStep) begin
                ShifterOut <= stepOut;
            end
        end
    end

endmodule

// File: tb/tb_shift_extend_unit.sv
// tb/tb_shift_extend_unit.sv - scoreboard bench for shift_extend_unit at STEP=1 and STEP=4
module tb_shift_extend_unit;
    import shift_extend_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start1, start4;
    logic [15:0] shIn;
    logic [4:0]  amt;
    logic        dir;
    logic [1:0]  mode;
    logic [11:0] imm;
    logic        busy1, done1, busy4, done4;
    logic [15:0] out1, zext1, sext1, out4, zext4, sext4;

    always #5 clk = ~clk;

    shift_extend_unit #(.WIDTH(16), .IMM_WIDTH(12), .AMT_WIDTH(5), .STEP(1)) dut1 (
        .CLK(clk), .Rst_n(rstN), .start(start1), .ShifterIn(shIn), .amt(amt), .dir(dir),
        .mode(mode), .imm(imm), .busy(busy1), .done(done1), .ShifterOut(out1),
        .ZeroExtOut(zext1), .SignExtOut(sext1)
    );

    shift_extend_unit #(.WIDTH(16), .IMM_WIDTH(12), .AMT_WIDTH(5), .STEP(4)) dut4 (
        .CLK(clk), .Rst_n(rstN), .start(start4), .ShifterIn(shIn), .amt(amt), .dir(dir),
        .mode(mode), .imm(imm), .busy(busy4), .done(done4), .ShifterOut(out4),
        .ZeroExtOut(zext4), .SignExtOut(sext4)
    );

    typedef struct {
        logic [15:0] res;
        logic [15:0] zext;
        logic [15:0] sext;
        int          doneCyc;
        int          nBusy;
    } exp_t;

    typedef struct {
        logic [15:0] din;
        logic [4:0]  a;
        logic        d;
        logic [1:0]  m;
        logic [11:0] im;
        logic [15:0] res;
        int          n;
    } vec_t;

    exp_t q1[$];
    exp_t q4[$];
    vec_t vecs[10];
    int   nChecks = 0;
    int   nFails  = 0;
    int   cyc     = 0;
    int   busyCnt1 = 0;
    int   busyCnt4 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compareDone(input string tag, input exp_t e, input logic [15:0] res,
                               input logic [15:0] z, input logic [15:0] s, input int nb);
        check({tag, "_result"}, 32'(res), 32'(e.res));
        check({tag, "_zext"}, 32'(z), 32'(e.zext));
        check({tag, "_sext"}, 32'(s), 32'(e.sext));
        check({tag, "_done_cycle"}, 32'(cyc), 32'(e.doneCyc));
        check({tag, "_busy_cycles"}, 32'(nb), 32'(e.nBusy));
    endtask

    // Monitor: pops the scoreboard whenever either unit signals done.
    always @(negedge clk) begin
        check("busy_done_exclusive", {30'b0, busy1 & done1, busy4 & done4}, 32'd0);
        if (!rstN) begin
            busyCnt1 = 0;
            busyCnt4 = 0;
        end else begin
            if (busy1) busyCnt1++;
            if (busy4) busyCnt4++;
            if (done1) begin
                if (q1.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL unexpected_done1: done with no pending op (t=%0t)", $time);
                end else begin
                    compareDone("step1", q1.pop_front(), out1, zext1, sext1, busyCnt1);
                end
                busyCnt1 = 0;
            end
            if (done4) begin
                if (q4.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL unexpected_done4: done with no pending op (t=%0t)", $time);
                end else begin
                    compareDone("step4", q4.pop_front(), out4, zext4, sext4, busyCnt4);
                end
                busyCnt4 = 0;
            end
        end
    end

    // Drives one request (caller is at a negedge), then queues its expectation.
    task automatic issue(input bit sel, input logic [15:0] din, input logic [4:0] a,
                         input logic d, input logic [1:0] m, input logic [11:0] im,
                         input logic [15:0] expRes, input int n);
        exp_t e;
        shIn = din;
        amt  = a;
        dir  = d;
        mode = m;
        imm  = im;
        if (sel) start4 = 1'b1;
        else     start1 = 1'b1;
        @(posedge clk);
        #1;
        start1    = 1'b0;
        start4    = 1'b0;
        e.res     = expRes;
        e.zext    = {4'h0, im};
        e.sext    = {{4{im[11]}}, im};
        e.doneCyc = cyc + n;
        e.nBusy   = n;
        if (sel) begin
            q4.push_back(e);
            check("zext_cycle1", 32'(zext4), 32'(e.zext));
            check("sext_cycle1", 32'(sext4), 32'(e.sext));
        end else begin
            q1.push_back(e);
            check("zext_cycle1", 32'(zext1), 32'(e.zext));
            check("sext_cycle1", 32'(sext1), 32'(e.sext));
        end
    endtask

    task automatic waitDone(input bit sel);
        bit got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = sel ? done4 : done1;
        end
        check(sel ? "done_seen_step4" : "done_seen_step1", 32'(got), 32'd1);
    endtask

    initial begin
        vecs[0] = '{16'h8001, 5'd3,  DIR_LEFT,  MODE_LOGICAL,  12'h800, 16'h0008, 3};
        vecs[1] = '{16'h8000, 5'd4,  DIR_RIGHT, MODE_ARITH,    12'h7FF, 16'hF800, 4};
        vecs[2] = '{16'h8000, 5'd20, DIR_RIGHT, MODE_ARITH,    12'h555, 16'hFFFF, 16};
        vecs[3] = '{16'h8000, 5'd20, DIR_RIGHT, MODE_LOGICAL,  12'hAAA, 16'h0000, 16};
        vecs[4] = '{16'hFFFF, 5'd31, DIR_LEFT,  MODE_LOGICAL,  12'h0F0, 16'h0000, 16};
        vecs[5] = '{16'h0001, 5'd1,  DIR_RIGHT, MODE_ROTATE,   12'h001, 16'h8000, 1};
        vecs[6] = '{16'h8001, 5'd1,  DIR_LEFT,  MODE_ARITH,    12'h000, 16'h0002, 1};
        vecs[7] = '{16'h8000, 5'd1,  DIR_RIGHT, MODE_RESERVED, 12'hFFF, 16'h4000, 1};
        vecs[8] = '{16'h0001, 5'd17, DIR_RIGHT, MODE_ROTATE,   12'h321, 16'h8000, 1};
        vecs[9] = '{16'h8000, 5'd16, DIR_LEFT,  MODE_ROTATE,   12'h9AB, 16'h8000, 0};

        rstN = 1'b0; start1 = 1'b0; start4 = 1'b0;
        shIn = '0; amt = '0; dir = 1'b0; mode = '0; imm = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",  {28'b0, busy1, done1, busy4, done4}, 32'd0);
        check("reset_out1",  32'(out1), 32'd0);
        check("reset_ext1",  {zext1, sext1}, 32'd0);
        check("reset_out4",  32'(out4), 32'd0);
        check("reset_ext4",  {zext4, sext4}, 32'd0);
        rstN = 1'b1;
        @(negedge clk);

        // STEP=4 unit, second request issued back-to-back in the DONE cycle.
        issue(1'b1, 16'h1234, 5'd6, DIR_LEFT, MODE_LOGICAL, 12'h800, 16'h8D00, 2);
        waitDone(1'b1);
        issue(1'b1, 16'h8000, 5'd5, DIR_RIGHT, MODE_ARITH, 12'h7FF, 16'hFC00, 2);
        waitDone(1'b1);
        @(negedge clk);
        issue(1'b1, 16'h1234, 5'd4, DIR_LEFT, MODE_ROTATE, 12'h000, 16'h2341, 1);
        waitDone(1'b1);
        @(negedge clk);
        check("step4_idle_after_done", {30'b0, busy4, done4}, 32'd0);
        check("step4_out_held", 32'(out4), 32'h2341);

        // STEP=1 unit: mix of IDLE accepts and back-to-back DONE accepts.
        for (int i = 0; i < 10; i++) begin
            issue(1'b0, vecs[i].din, vecs[i].a, vecs[i].d, vecs[i].m, vecs[i].im,
                  vecs[i].res, vecs[i].n);
            waitDone(1'b0);
            if (i % 2 == 1) @(negedge clk);
        end

        // A start pulse mid-SHIFT must not disturb the running operation.
        @(negedge clk);
        issue(1'b0, 16'h00F0, 5'd10, DIR_LEFT, MODE_LOGICAL, 12'h123, 16'hC000, 10);
        @(negedge clk);
        @(negedge clk);
        shIn = 16'hFFFF;
        imm  = 12'hFFF;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        check("midshift_busy", 32'(busy1), 32'd1);
        check("midshift_out_held", 32'(out1), 32'h8000);
        check("midshift_zext", 32'(zext1), 32'h0123);
        check("midshift_sext", 32'(sext1), 32'h0123);
        waitDone(1'b0);

        // Reset in cycle 2 of a 10-step shift discards it without a done pulse.
        @(negedge clk);
        issue(1'b0, 16'h1234, 5'd10, DIR_LEFT, MODE_LOGICAL, 12'hABC, 16'h0000, 10);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        check("async_reset_flags", {30'b0, busy1, done1}, 32'd0);
        check("async_reset_out", 32'(out1), 32'd0);
        check("async_reset_ext", {zext1, sext1}, 32'd0);
        q1.delete();
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        issue(1'b0, 16'hFF00, 5'd8, DIR_RIGHT, MODE_LOGICAL, 12'h0FF, 16'h00FF, 8);
        waitDone(1'b0);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(q1.size() + q4.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
